com_bus_rr_arbiter: RTL and testbench
=====================================

// Module: com_bus_rr_arbiter
// PURPOSE
//  Parametrised common-bus arbiter for the N-core MESI cache cluster; replaces fixed per-requester grant logic.
//  Two independent single-owner channels: PROC (DL/IL miss/writeback) and SNOOP (snoop responses + memory snoop).
//  Fair round-robin per channel, hold-until-release handshake, turnaround gap, watchdog on stuck owners.
// PARAMETERS
//  N_PROC    8    processor-side requesters (4 DL + 4 IL)
//  N_SNOOP   4    snoop-side requesters (DL only); memory snoop is extra index N_SNOOP
//  MAX_HOLD  64   cycles an owner may hold a grant before hold_timeout; 0 disables watchdog
//  TURN_GAP  1    idle cycles after release before next grant on same channel (0..3)
// PORTS
//  clk               in   1            bus clock, rising edge
//  rst               in   1            async active-high reset
//  req_proc          in   N_PROC       Com_Bus_Req_proc per requester, level
//  gnt_proc          out  N_PROC       Com_Bus_Gnt_proc, one-hot or zero
//  req_snoop         in   N_SNOOP      Com_Bus_Req_snoop per requester, level
//  gnt_snoop         out  N_SNOOP      Com_Bus_Gnt_snoop, one-hot or zero
//  mem_snoop_req     in   1            Mem_snoop_req, level
//  mem_snoop_gnt     out  1            Mem_snoop_gnt
//  proc_owner        out  $clog2(N_PROC)   index of current PROC owner (valid when proc_busy)
//  proc_busy         out  1            PROC channel in GRANT
//  snoop_busy        out  1            SNOOP channel in GRANT
//  hold_timeout      out  2            1-cycle pulse: [0] PROC, [1] SNOOP exceeded MAX_HOLD
// BEHAVIOUR
//  Reset: all gnt*, proc_owner, busy, hold_timeout = 0; both FSMs IDLE; RR pointers = 0.
//  Per-channel FSM: IDLE -> GRANT -> GAP -> IDLE (GAP skipped when TURN_GAP=0: GRANT -> IDLE).
//   IDLE: any req sampled high at edge k -> gnt asserted registered at edge k (visible after k); 1-cycle latency.
//   GRANT: gnt held while owner req=1; other reqs ignored. Owner req=0 at edge -> gnt=0 same edge, enter GAP.
//   GAP: count TURN_GAP cycles, no grants, then IDLE. Pending reqs re-arbitrated in IDLE.
//  Round-robin: winner = first requester at or above ptr, wrapping from N-1 to 0; on grant ptr <= winner+1 mod N.
//  SNOOP channel: memory snoop (index N_SNOOP) joins the rotation as lowest priority only;
//   mem_snoop_gnt issued only when no req_snoop bit is set in that IDLE cycle; does not move ptr.
//  Channels independent: a PROC grant and a SNOOP grant may be active simultaneously (snoop during bus txn).
//  Requester dropping req before grant: no grant issued; req rising in same edge as owner release waits GAP.
//  Watchdog: hold counter cleared on entry to GRANT, +1 per GRANT cycle, saturates; equality with MAX_HOLD
//   -> hold_timeout bit pulses once per grant. Grant is NOT revoked.
//  Async rst mid-GRANT: grants drop immediately, counters/ptrs cleared; req levels re-arbitrated after deassert.
//  Invariants: $onehot0(gnt_proc); $onehot0({mem_snoop_gnt,gnt_snoop}); gnt bit implies matching req high
//   or first cycle after its release edge is zero.
// STRUCTURE
//  Package com_bus_arb_pkg: typedef enum {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_t; MAX_TURN_GAP=3.
//  Sub-module rr_pick #(N): combinational one-hot round-robin select from req vector and ptr; instantiated
//   once per channel. Top holds the two FSMs, pointers, gap and hold counters.
// TESTING
//  1. Reset, req_proc=8'h01 held 5 cycles -> gnt_proc=8'h01 one cycle later, proc_owner=0, proc_busy=1; drop -> gnt 0, 1 gap.
//  2. req_proc=8'hFF held, each owner releases after 2 cycles -> grants 0,1,...,7,0 in order, one gap between.
//  3. req_snoop=4'h4 and mem_snoop_req=1 same cycle -> gnt_snoop=4'h4 first; mem_snoop_gnt only after its release+gap.
//  4. PROC owner 3 granted, then req_snoop=4'h2 -> gnt_snoop=4'h2 while gnt_proc=8'h08 stays; both busy=1.
//  5. MAX_HOLD=16, owner holds 40 cycles -> hold_timeout[0] pulses exactly once at cycle 16, gnt stays high.
//  6. rst asserted mid-GRANT (async, between edges) -> all gnt 0 immediately; after release req 8'h10 -> gnt 8'h10 (ptr 0).

Source files
------------

// File: rtl/com_bus_arb_pkg.sv
// Shared types and constants for the common-bus round-robin arbiter.
//   arb_state_t  : per-channel FSM state (IDLE -> GRANT -> GAP -> IDLE)
//   MAX_TURN_GAP : largest supported turnaround gap in cycles
//   GAP_W        : width of the turnaround gap counter
package com_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    localparam int unsigned MAX_TURN_GAP = 3;
    localparam int unsigned GAP_W        = $clog2(MAX_TURN_GAP + 1);

endpackage

// File: rtl/com_bus_rr_arbiter_rr_pick.sv
// Combinational round-robin select: first requester at or above ptr, wrapping N-1 -> 0.
//   req   : request vector
//   ptr   : current round-robin pointer
//   gnt_c : one-hot winner (zero when no request)
//   idx_c : winner index (zero when no request)
//   any_c : at least one request present
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_c,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 any_c
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] j;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = IW'((32'(ptr) + i) % N);
            if (!any_c && req[j]) begin
                any_c    = 1'b1;
                gnt_c[j] = 1'b1;
                idx_c    = j;
            end
        end
    end

endmodule

// File: rtl/com_bus_rr_arbiter.sv
// Common-bus arbiter with two independent single-owner channels (PROC and SNOOP).
// Round-robin per channel, hold-until-release, turnaround gap, hold watchdog.
//   clk, rst             : bus clock, async active-high reset
//   req_proc / gnt_proc  : processor-side requests / one-hot grant
//   req_snoop / gnt_snoop: snoop-side requests / one-hot grant
//   mem_snoop_req / _gnt : memory snoop, lowest priority on the SNOOP channel
//   proc_owner           : index of current PROC owner (valid while proc_busy)
//   proc_busy/snoop_busy : channel currently granted
//   hold_timeout         : [0] PROC, [1] SNOOP single-cycle watchdog pulse
module com_bus_rr_arbiter
    import com_bus_arb_pkg::*;
#(
    parameter int unsigned N_PROC   = 8,
    parameter int unsigned N_SNOOP  = 4,
    parameter int unsigned MAX_HOLD = 64,
    parameter int unsigned TURN_GAP = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PROC-1:0]         req_proc,
    output logic [N_PROC-1:0]         gnt_proc,
    input  logic [N_SNOOP-1:0]        req_snoop,
    output logic [N_SNOOP-1:0]        gnt_snoop,
    input  logic                      mem_snoop_req,
    output logic                      mem_snoop_gnt,
    output logic [$clog2(N_PROC)-1:0] proc_owner,
    output logic                      proc_busy,
    output logic                      snoop_busy,
    output logic [1:0]                hold_timeout
);

    localparam int unsigned PP_W   = $clog2(N_PROC);
    localparam int unsigned SP_W   = $clog2(N_SNOOP);
    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_t          proc_state, snp_state;
    logic [PP_W-1:0]     proc_ptr;
    logic [SP_W-1:0]     snp_ptr;
    logic [GAP_W-1:0]    proc_gap, snp_gap;
    logic [HOLD_W-1:0]   proc_hold, snp_hold;
    logic                proc_to, snp_to;

    logic [N_PROC-1:0]   proc_gnt_c;
    logic [PP_W-1:0]     proc_idx_c;
    logic                proc_any_c;
    logic [N_SNOOP-1:0]  snp_gnt_c;
    logic [SP_W-1:0]     snp_idx_c;
    logic                snp_any_c;
    logic                snp_owner_req_c;

    rr_pick #(.N(N_PROC)) u_pick_proc (
        .req   (req_proc),
        .ptr   (proc_ptr),
        .gnt_c (proc_gnt_c),
        .idx_c (proc_idx_c),
        .any_c (proc_any_c)
    );

    rr_pick #(.N(N_SNOOP)) u_pick_snoop (
        .req   (req_snoop),
        .ptr   (snp_ptr),
        .gnt_c (snp_gnt_c),
        .idx_c (snp_idx_c),
        .any_c (snp_any_c)
    );

    // Current SNOOP owner (core or memory) still requesting.
    assign snp_owner_req_c = (|(gnt_snoop & req_snoop)) | (mem_snoop_gnt & mem_snoop_req);

    assign hold_timeout = {snp_to, proc_to};

    // PROC channel FSM, pointer, gap and watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proc_state <= ARB_IDLE;
            gnt_proc   <= '0;
            proc_owner <= '0;
            proc_busy  <= 1'b0;
            proc_ptr   <= '0;
            proc_gap   <= '0;
            proc_hold  <= '0;
            proc_to    <= 1'b0;
        end else begin
            proc_to <= 1'b0;
            case (proc_state)
                ARB_IDLE: begin
                    if (proc_any_c) begin
                        gnt_proc   <= proc_gnt_c;
                        proc_owner <= proc_idx_c;
                        proc_busy  <= 1'b1;
                        proc_hold  <= '0;
                        proc_ptr   <= (proc_idx_c == PP_W'(N_PROC - 1)) ? '0 : proc_idx_c + PP_W'(1);
                        proc_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!(|(gnt_proc & req_proc))) begin
                        gnt_proc   <= '0;
                        proc_busy  <= 1'b0;
                        proc_gap   <= '0;
                        proc_state <= (TURN_GAP == 0) ? ARB_IDLE : ARB_GAP;
                    end else if (MAX_HOLD != 0 && proc_hold != HOLD_W'(MAX_HOLD)) begin
                        // Saturating count; pulse only on reaching the limit.
                        proc_hold <= proc_hold + HOLD_W'(1);
                        proc_to   <= (proc_hold + HOLD_W'(1)) == HOLD_W'(MAX_HOLD);
                    end
                end
                ARB_GAP: begin
                    if (proc_gap == GAP_W'(TURN_GAP - 1)) proc_state <= ARB_IDLE;
                    else                                  proc_gap   <= proc_gap + GAP_W'(1);
                end
                default: proc_state <= ARB_IDLE;
            endcase
        end
    end

    // SNOOP channel FSM; memory snoop wins only when no core snoop request is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snp_state     <= ARB_IDLE;
            gnt_snoop     <= '0;
            mem_snoop_gnt <= 1'b0;
            snoop_busy    <= 1'b0;
            snp_ptr       <= '0;
            snp_gap       <= '0;
            snp_hold      <= '0;
            snp_to        <= 1'b0;
        end else begin
            snp_to <= 1'b0;
            case (snp_state)
                ARB_IDLE: begin
                    if (snp_any_c) begin
                        gnt_snoop  <= snp_gnt_c;
                        snoop_busy <= 1'b1;
                        snp_hold   <= '0;
                        snp_ptr    <= (snp_idx_c == SP_W'(N_SNOOP - 1)) ? '0 : snp_idx_c + SP_W'(1);
                        snp_state  <= ARB_GRANT;
                    end else if (mem_snoop_req) begin
                        mem_snoop_gnt <= 1'b1;
                        snoop_busy    <= 1'b1;
                        snp_hold      <= '0;
                        snp_state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!snp_owner_req_c) begin
                        gnt_snoop     <= '0;
                        mem_snoop_gnt <= 1'b0;
                        snoop_busy    <= 1'b0;
                        snp_gap       <= '0;
                        snp_state     <= (TURN_GAP == 0) ? ARB_IDLE : ARB_GAP;
                    end else if (MAX_HOLD != 0 && snp_hold != HOLD_W'(MAX_HOLD)) begin
                        snp_hold <= snp_hold + HOLD_W'(1);
                        snp_to   <= (snp_hold + HOLD_W'(1)) == HOLD_W'(MAX_HOLD);
                    end
                end
                ARB_GAP: begin
                    if (snp_gap == GAP_W'(TURN_GAP - 1)) snp_state <= ARB_IDLE;
                    else                                 snp_gap   <= snp_gap + GAP_W'(1);
                end
                default: snp_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_com_bus_rr_arbiter.sv
// Directed self-checking bench for com_bus_rr_arbiter (N_PROC=8, N_SNOOP=4, MAX_HOLD=16, TURN_GAP=1).
module tb_com_bus_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_proc;
    logic [7:0] gnt_proc;
    logic [3:0] req_snoop;
    logic [3:0] gnt_snoop;
    logic       mem_snoop_req;
    logic       mem_snoop_gnt;
    logic [2:0] proc_owner;
    logic       proc_busy;
    logic       snoop_busy;
    logic [1:0] hold_timeout;

    int tests_run;
    int tests_failed;

    com_bus_rr_arbiter #(
        .N_PROC   (8),
        .N_SNOOP  (4),
        .MAX_HOLD (16),
        .TURN_GAP (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_proc      (req_proc),
        .gnt_proc      (gnt_proc),
        .req_snoop     (req_snoop),
        .gnt_snoop     (gnt_snoop),
        .mem_snoop_req (mem_snoop_req),
        .mem_snoop_gnt (mem_snoop_gnt),
        .proc_owner    (proc_owner),
        .proc_busy     (proc_busy),
        .snoop_busy    (snoop_busy),
        .hold_timeout  (hold_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_proc      = '0;
        req_snoop     = '0;
        mem_snoop_req = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_proc      = 8'hFF;
        req_snoop     = 4'hF;
        mem_snoop_req = 1'b1;
        rst           = 1'b1;
        tick();
        tick();
        tests_run++;
        if (gnt_proc !== 8'h00) begin tests_failed++; $display("FAIL reset_gnt_proc: got %h expected 00", gnt_proc); end
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop} !== 5'h00) begin tests_failed++; $display("FAIL reset_gnt_snoop: got %h expected 00", {mem_snoop_gnt, gnt_snoop}); end
        tests_run++;
        if ({proc_owner, proc_busy, snoop_busy, hold_timeout} !== 7'h00) begin tests_failed++; $display("FAIL reset_status: got %h expected 00", {proc_owner, proc_busy, snoop_busy, hold_timeout}); end
        req_proc      = '0;
        req_snoop     = '0;
        mem_snoop_req = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        req_proc = 8'h01;
        tick();
        tests_run++;
        if ({gnt_proc, proc_owner, proc_busy} !== {8'h01, 3'd0, 1'b1}) begin tests_failed++; $display("FAIL single_first: got %h/%0d/%b expected 01/0/1", gnt_proc, proc_owner, proc_busy); end
        for (int c = 0; c < 4; c++) begin
            tick();
            tests_run++;
            if (gnt_proc !== 8'h01) begin tests_failed++; $display("FAIL single_hold%0d: got %h expected 01", c, gnt_proc); end
        end
        req_proc = 8'h00;
        tick();
        tests_run++;
        if ({gnt_proc, proc_busy} !== 9'h000) begin tests_failed++; $display("FAIL single_release: got %h/%b expected 00/0", gnt_proc, proc_busy); end
        req_proc = 8'h01;
        tick();
        tests_run++;
        if (gnt_proc !== 8'h00) begin tests_failed++; $display("FAIL single_gap: got %h expected 00", gnt_proc); end
        tick();
        tests_run++;
        if (gnt_proc !== 8'h01) begin tests_failed++; $display("FAIL single_regrant: got %h expected 01", gnt_proc); end
        req_proc = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        do_reset();
        req_proc = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            tick();
            tests_run++;
            if ({gnt_proc, proc_owner} !== {exp, 3'(k % 8)}) begin tests_failed++; $display("FAIL rr_grant%0d: got %h/%0d expected %h/%0d", k, gnt_proc, proc_owner, exp, k % 8); end
            tick();
            tests_run++;
            if (gnt_proc !== exp) begin tests_failed++; $display("FAIL rr_hold%0d: got %h expected %h", k, gnt_proc, exp); end
            req_proc[k % 8] = 1'b0;
            tick();
            tests_run++;
            if (gnt_proc !== 8'h00) begin tests_failed++; $display("FAIL rr_release%0d: got %h expected 00", k, gnt_proc); end
            req_proc[k % 8] = 1'b1;
            tick();
            tests_run++;
            if (gnt_proc !== 8'h00) begin tests_failed++; $display("FAIL rr_gap%0d: got %h expected 00", k, gnt_proc); end
        end
        req_proc = 8'h00;
        tick();
    endtask

    task automatic test_snoop_mem();
        do_reset();
        req_snoop     = 4'h4;
        mem_snoop_req = 1'b1;
        tick();
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop, snoop_busy} !== {1'b0, 4'h4, 1'b1}) begin tests_failed++; $display("FAIL snoop_first: got mem=%b gnt=%h busy=%b expected mem=0 gnt=4 busy=1", mem_snoop_gnt, gnt_snoop, snoop_busy); end
        tick();
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop} !== 5'h04) begin tests_failed++; $display("FAIL snoop_hold: got %h expected 04", {mem_snoop_gnt, gnt_snoop}); end
        req_snoop = 4'h0;
        tick();
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop} !== 5'h00) begin tests_failed++; $display("FAIL snoop_release: got %h expected 00", {mem_snoop_gnt, gnt_snoop}); end
        tick();
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop} !== 5'h00) begin tests_failed++; $display("FAIL snoop_gap: got %h expected 00", {mem_snoop_gnt, gnt_snoop}); end
        tick();
        tests_run++;
        if ({mem_snoop_gnt, gnt_snoop, snoop_busy} !== {1'b1, 4'h0, 1'b1}) begin tests_failed++; $display("FAIL mem_grant: got mem=%b gnt=%h busy=%b expected mem=1 gnt=0 busy=1", mem_snoop_gnt, gnt_snoop, snoop_busy); end
        mem_snoop_req = 1'b0;
        tick();
        tests_run++;
        if (mem_snoop_gnt !== 1'b0) begin tests_failed++; $display("FAIL mem_release: got %b expected 0", mem_snoop_gnt); end
        tick();
        // Memory grant must not have moved the pointer: last core winner was 2, so 3 wins.
        req_snoop = 4'hF;
        tick();
        tests_run++;
        if (gnt_snoop !== 4'h8) begin tests_failed++; $display("FAIL snoop_ptr_after_mem: got %h expected 8", gnt_snoop); end
        req_snoop = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_concurrent();
        do_reset();
        req_proc = 8'h08;
        tick();
        tests_run++;
        if ({gnt_proc, proc_owner} !== {8'h08, 3'd3}) begin tests_failed++; $display("FAIL conc_proc: got %h/%0d expected 08/3", gnt_proc, proc_owner); end
        req_snoop = 4'h2;
        req_proc  = 8'h09;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop} !== {8'h08, 4'h2}) begin tests_failed++; $display("FAIL conc_both: got proc=%h snoop=%h expected proc=08 snoop=2", gnt_proc, gnt_snoop); end
        tests_run++;
        if ({proc_busy, snoop_busy} !== 2'b11) begin tests_failed++; $display("FAIL conc_busy: got %b expected 11", {proc_busy, snoop_busy}); end
        req_snoop = 4'h0;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop} !== {8'h08, 4'h0}) begin tests_failed++; $display("FAIL conc_snoop_drop: got proc=%h snoop=%h expected proc=08 snoop=0", gnt_proc, gnt_snoop); end
        req_proc = 8'h00;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        int pulses;
        int pulse_at;
        int gnt_bad;
        int snp_bad;
        do_reset();
        pulses   = 0;
        pulse_at = -1;
        gnt_bad  = 0;
        snp_bad  = 0;
        req_proc = 8'h04;
        tick();
        tests_run++;
        if ({gnt_proc, hold_timeout} !== {8'h04, 2'b00}) begin tests_failed++; $display("FAIL wd_grant: got %h/%b expected 04/00", gnt_proc, hold_timeout); end
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (hold_timeout[0]) begin pulses++; pulse_at = c; end
            if (hold_timeout[1]) snp_bad++;
            if (gnt_proc !== 8'h04) gnt_bad++;
        end
        tests_run++;
        if (pulses !== 1) begin tests_failed++; $display("FAIL wd_pulse_count: got %0d expected 1", pulses); end
        tests_run++;
        if (pulse_at !== 16) begin tests_failed++; $display("FAIL wd_pulse_cycle: got %0d expected 16", pulse_at); end
        tests_run++;
        if (gnt_bad !== 0) begin tests_failed++; $display("FAIL wd_gnt_kept: got %0d bad cycles expected 0", gnt_bad); end
        tests_run++;
        if (snp_bad !== 0) begin tests_failed++; $display("FAIL wd_snoop_bit: got %0d pulses expected 0", snp_bad); end
        req_proc = 8'h00;
        tick();
        tests_run++;
        if (gnt_proc !== 8'h00) begin tests_failed++; $display("FAIL wd_release: got %h expected 00", gnt_proc); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req_proc  = 8'h20;
        req_snoop = 4'h1;
        tick();
        tests_run++;
        if ({gnt_proc, gnt_snoop} !== {8'h20, 4'h1}) begin tests_failed++; $display("FAIL arst_pre: got proc=%h snoop=%h expected proc=20 snoop=1", gnt_proc, gnt_snoop); end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({gnt_proc, gnt_snoop, mem_snoop_gnt, proc_busy, snoop_busy} !== 15'h0) begin tests_failed++; $display("FAIL arst_immediate: got proc=%h snoop=%h busy=%b expected all 0", gnt_proc, gnt_snoop, {proc_busy, snoop_busy}); end
        // Bits 4 and 7: ptr 0 picks 4, a stale ptr of 6 would pick 7.
        req_proc  = 8'h90;
        req_snoop = 4'h0;
        #2;
        rst = 1'b0;
        tick();
        tests_run++;
        if ({gnt_proc, proc_owner} !== {8'h10, 3'd4}) begin tests_failed++; $display("FAIL arst_regrant: got %h/%0d expected 10/4", gnt_proc, proc_owner); end
        req_proc = 8'h00;
        tick();
        tick();
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        req_proc      = '0;
        req_snoop     = '0;
        mem_snoop_req = 1'b0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_snoop_mem();
        test_concurrent();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
